// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared command/state encodings and constants for the HI/LO unit.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_MULT  = 2'b00,
        CMD_MULTU = 2'b01,
        CMD_DIV   = 2'b10,
        CMD_DIVU  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        SIGN,
        DZ,
        DONE
    } state_e;

    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;
    localparam logic ZERO    = 1'b0;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational shift-add (multiply) or restoring shift-subtract (divide) step.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc_n
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   top;
    logic [XLEN:0]   diff;
    logic [2*XLEN:0] sh;

    // The partial remainder stays below 2*b, so the borrow bit of diff alone decides restore.
    always_comb begin
        sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc[0]}} & b};
        sh    = {acc, 1'b0};
        top   = sh[2*XLEN:XLEN];
        diff  = top - {1'b0, b};
        acc_n = !is_div ? {sum, acc[XLEN-1:1]}
              : diff[XLEN] ? sh[2*XLEN-1:0]
              : {diff[XLEN-1:0], sh[XLEN-1:1], 1'b1};
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle mult/multu/div/divu controller owning HI/LO.
// Optional mthi/mtlo write port enabled by MULDIV_MTHILO_EN.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic [1:0]      cmd,
    input  logic [XLEN-1:0] regaData,
    input  logic [XLEN-1:0] regbData,
    input  logic            flush,
`ifdef MULDIV_MTHILO_EN
    input  logic [1:0]      hilo_we,
    input  logic [XLEN-1:0] hilo_wdata,
`endif
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e            state, state_n;
    logic [2*XLEN-1:0] acc, acc_n, prod;
    logic [XLEN-1:0]   opb, mag_a, mag_b, quo, rem;
    logic [CNT_W-1:0]  cnt;
    logic              op_div, sa, sb, is_div, is_sgn, dz, accept;

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .is_div(op_div),
        .acc   (acc),
        .b     (opb),
        .acc_n (acc_n)
    );

    always_comb begin
        is_div  = cmd == CMD_DIV || cmd == CMD_DIVU;
        is_sgn  = cmd == CMD_MULT || cmd == CMD_DIV;
        mag_a   = is_sgn && regaData[XLEN-1] ? -regaData : regaData;
        mag_b   = is_sgn && regbData[XLEN-1] ? -regbData : regbData;
        dz      = is_div && regbData == '0;
        accept  = state == IDLE && req && !flush;
        prod    = sa ^ sb ? -acc : acc;
        quo     = sa ^ sb ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem     = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        state_n = state;
        case (state)
            IDLE:     state_n = accept ? (dz ? DZ : CALC) : IDLE;
            CALC:     state_n = cnt == CNT_W'(1) ? SIGN : CALC;
            SIGN, DZ: state_n = DONE;
            default:  state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
        stall = (state == IDLE && req) || (state != IDLE && state != DONE);
        busy  = state != IDLE;
        done  = state == DONE ? VALID : INVALID;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            opb      <= '0;
            cnt      <= '0;
            op_div   <= ZERO;
            sa       <= ZERO;
            sb       <= ZERO;
            hi       <= '0;
            lo       <= '0;
            div_zero <= ZERO;
        end else begin
            state <= state_n;
`ifdef MULDIV_MTHILO_EN
            if (state == IDLE && hilo_we[1]) hi <= hilo_wdata;
            if (state == IDLE && hilo_we[0]) lo <= hilo_wdata;
`endif
            // Divide-by-zero keeps the raw dividend so DZ can copy it into HI unchanged.
            if (accept) begin
                op_div   <= is_div;
                sa       <= is_sgn && regaData[XLEN-1];
                sb       <= is_sgn && regbData[XLEN-1];
                opb      <= is_div ? mag_b : mag_a;
                acc      <= {{XLEN{1'b0}}, is_div ? (dz ? regaData : mag_a) : mag_b};
                cnt      <= CNT_W'(XLEN);
                div_zero <= ZERO;
            end
            if (state == CALC) begin
                acc <= acc_n;
                cnt <= cnt - CNT_W'(1);
            end
            if (state == SIGN && !flush) {hi, lo} <= op_div ? {rem, quo} : prod;
            if (state == DZ && !flush) begin
                hi       <= acc[XLEN-1:0];
                lo       <= '1;
                div_zero <= VALID;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and randomized checks of muldiv_ctrl against a cycle-countdown reference model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, flush;
    logic [1:0]  cmd;
    logic [31:0] regaData, regbData;
    logic        stall, busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int ndone  = 0;

    int          m_left;
    logic [31:0] m_hi, m_lo;
    logic        m_dz;
    logic [64:0] m_pend;

    muldiv_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .cmd     (cmd),
        .regaData(regaData),
        .regbData(regbData),
        .flush   (flush),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result of one operation as {div_zero, hi, lo}, straight from the arithmetic definition.
    function automatic logic [64:0] model_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        longint      sq, sr;
        logic [63:0] p, ua, ub;
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (c == 2'b00) begin
            p = 64'(longint'($signed(a)) * longint'($signed(b)));
            return {1'b0, p};
        end
        if (c == 2'b01) begin
            p = ua * ub;
            return {1'b0, p};
        end
        if (b == 32'b0) return {1'b1, a, 32'hFFFFFFFF};
        if (c == 2'b10) begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            return {1'b0, sr[31:0], sq[31:0]};
        end
        p = ua / ub;
        ua = ua % ub;
        return {1'b0, ua[31:0], p[31:0]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_hi   = 0;
            m_lo   = 0;
            m_dz   = 0;
        end else if (m_left == 0) begin
            if (req && !flush) begin
                m_pend = model_op(cmd, regaData, regbData);
                m_left = m_pend[64] ? 2 : 34;
                m_dz   = 0;
            end
        end else if (flush) begin
            m_left = 0;
        end else begin
            m_left--;
            if (m_left == 1) {m_dz, m_hi, m_lo} = m_pend;
        end
    end

    always @(negedge clk) begin
        chk("stall", 65'(stall), 65'((m_left == 0 && req) || m_left > 1));
        chk("busy", 65'(busy), 65'(m_left != 0));
        chk("done", 65'(done), 65'(m_left == 1));
        chk("div_zero", 65'(div_zero), 65'(m_dz));
        chk("hi", 65'(hi), 65'(m_hi));
        chk("lo", 65'(lo), 65'(m_lo));
        if (done === 1'b1) ndone++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 60) begin
            step();
            k++;
        end
        chk("idle_timeout", 65'(busy), 65'(0));
    endtask

    task automatic run_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b, output int lat);
        wait_idle();
        cmd = c;
        regaData = a;
        regbData = b;
        req = 1'b1;
        step();
        req = 1'b0;
        regaData = $urandom;
        regbData = $urandom;
        lat = 1;
        while (!done && lat < 60) begin
            step();
            lat++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        int lat, n, nd0;
        rst = 1'b1;
        req = 1'b0;
        flush = 1'b0;
        cmd = 2'b00;
        regaData = 0;
        regbData = 0;
        chk("model_mult", model_op(2'b00, 32'hFFFFFFFF, 32'h2), {1'b0, 64'hFFFFFFFF_FFFFFFFE});
        chk("model_div", model_op(2'b10, 32'hFFFFFFF9, 32'h2), {1'b0, 64'hFFFFFFFF_FFFFFFFD});
        chk("model_intmin", model_op(2'b10, 32'h80000000, 32'hFFFFFFFF), {1'b0, 64'h00000000_80000000});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_hi", 65'(hi), 65'(0));
        chk("reset_busy", 65'(busy), 65'(0));

        run_op(2'b00, 32'hFFFFFFFF, 32'h2, lat);
        chk("mult_lat", 65'(lat), 65'(34));
        chk("mult_hi", 65'(hi), 65'(32'hFFFFFFFF));
        chk("mult_lo", 65'(lo), 65'(32'hFFFFFFFE));
        chk("mult_stall_done", 65'(stall), 65'(0));

        run_op(2'b01, 32'hFFFFFFFF, 32'h2, lat);
        chk("multu_lat", 65'(lat), 65'(34));
        chk("multu_hi", 65'(hi), 65'(32'h1));
        chk("multu_lo", 65'(lo), 65'(32'hFFFFFFFE));

        run_op(2'b10, 32'hFFFFFFF9, 32'h2, lat);
        chk("div_lo", 65'(lo), 65'(32'hFFFFFFFD));
        chk("div_hi", 65'(hi), 65'(32'hFFFFFFFF));

        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat);
        chk("intmin_lo", 65'(lo), 65'(32'h80000000));
        chk("intmin_hi", 65'(hi), 65'(0));

        // Divide by zero, then a second divu held on req across DONE.
        wait_idle();
        cmd = 2'b11;
        regaData = 32'h1234;
        regbData = 0;
        req = 1'b1;
        step();
        regaData = 100;
        regbData = 7;
        lat = 1;
        while (!done && lat < 60) begin
            step();
            lat++;
        end
        chk("dz_lat", 65'(lat), 65'(2));
        chk("dz_flag", 65'(div_zero), 65'(1));
        chk("dz_lo", 65'(lo), 65'(32'hFFFFFFFF));
        chk("dz_hi", 65'(hi), 65'(32'h1234));
        step();
        n = 1;
        while (!done && n < 60) begin
            step();
            n++;
            req = 1'b0;
        end
        chk("b2b_gap", 65'(n), 65'(35));
        chk("divu_lo", 65'(lo), 65'(14));
        chk("divu_hi", 65'(hi), 65'(2));
        chk("divu_dz_clear", 65'(div_zero), 65'(0));

        run_op(2'b11, 32'hBA, 32'h10, lat);
        chk("preload_hi", 65'(hi), 65'(32'hA));
        chk("preload_lo", 65'(lo), 65'(32'hB));
        wait_idle();
        cmd = 2'b00;
        regaData = $urandom;
        regbData = $urandom;
        req = 1'b1;
        step();
        req = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        nd0 = ndone;
        chk("flush_busy", 65'(busy), 65'(0));
        chk("flush_hi", 65'(hi), 65'(32'hA));
        chk("flush_lo", 65'(lo), 65'(32'hB));
        repeat (40) step();
        chk("flush_no_done", 65'(ndone - nd0), 65'(0));

        cmd = 2'b01;
        regaData = $urandom;
        regbData = $urandom;
        req = 1'b1;
        step();
        req = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        chk("rst_hi", 65'(hi), 65'(0));
        chk("rst_lo", 65'(lo), 65'(0));
        chk("rst_busy", 65'(busy), 65'(0));
        chk("rst_stall", 65'(stall), 65'(0));
        step();
        rst = 1'b0;

        nd0 = ndone;
        for (int i = 0; i < 3000; i++) begin
            req = ($urandom % 3) == 0;
            cmd = 2'($urandom);
            regaData = pick();
            regbData = pick();
            flush = ($urandom % 150) == 0;
            step();
        end
        req = 1'b0;
        flush = 1'b0;
        wait_idle();
        chk("rand_done_seen", 65'(ndone - nd0 > 10), 65'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
